// File: rtl/vx_tma_tile_dma_pkg.sv
// Shared types for the TMA tile-copy engine: descriptor layout, FSM states
// and the slot-index width helper.
package vx_tma_tile_dma_pkg;

  localparam int TMA_ADDR_WIDTH = 32;
  localparam int TMA_DIM_WIDTH  = 16;

  typedef struct packed {
    logic [TMA_ADDR_WIDTH-1:0] src_base;
    logic [TMA_ADDR_WIDTH-1:0] dst_base;
    logic [TMA_ADDR_WIDTH-1:0] src_stride;
    logic [TMA_ADDR_WIDTH-1:0] dst_stride;
    logic [TMA_DIM_WIDTH-1:0]  rows;
    logic [TMA_DIM_WIDTH-1:0]  cols;
  } tma_desc_t;

  typedef enum logic [1:0] {
    TMA_IDLE  = 2'd0,
    TMA_ISSUE = 2'd1,
    TMA_DRAIN = 2'd2,
    TMA_DONE  = 2'd3
  } tma_state_e;

  function automatic int tma_slot_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_tma_tile_dma_alloc.sv
// Read-slot allocator: hands out the lowest free slot; a released slot only
// becomes visible as free from the following cycle.
module vx_tma_tile_dma_alloc
  import vx_tma_tile_dma_pkg::*;
#(
  parameter int SIZE = 8,
  localparam int IDX_W = tma_slot_bits(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             acq,
  input  logic             rel,
  input  logic [IDX_W-1:0] rel_idx,
  output logic             avail,
  output logic [IDX_W-1:0] alloc_idx,
  output logic [SIZE-1:0]  free_mask
);

  logic [SIZE-1:0] free_q;
  logic [SIZE-1:0] acq_oh;
  logic [SIZE-1:0] rel_oh;

  always_comb begin
    alloc_idx = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (free_q[i]) alloc_idx = IDX_W'(i);
    end
  end

  assign avail     = |free_q;
  assign free_mask = free_q;
  assign acq_oh    = acq ? (SIZE'(1) << alloc_idx) : '0;
  assign rel_oh    = rel ? (SIZE'(1) << rel_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      free_q <= '1;
    end else begin
      free_q <= (free_q & ~acq_oh) | rel_oh;
    end
  end

endmodule

// File: rtl/vx_tma_tile_dma.sv
// 2D tile-copy engine: walks a descriptor row by row issuing read beats and
// forwards each (possibly out-of-order) response as a local-memory write.
// Optional TMA_PERF_EN adds saturating beat and stall counters.
module vx_tma_tile_dma
  import vx_tma_tile_dma_pkg::*;
#(
  parameter int NUM_LANES     = 4,
  parameter int WORD_SIZE     = 4,
  parameter int ADDR_WIDTH    = TMA_ADDR_WIDTH,
  parameter int DIM_WIDTH     = TMA_DIM_WIDTH,
  parameter int MAX_PENDING   = 8,
  parameter int CMD_TAG_WIDTH = 8,
  localparam int SLOT_BITS = tma_slot_bits(MAX_PENDING),
  localparam int DATA_BITS = NUM_LANES * WORD_SIZE * 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  tma_desc_t                cmd_desc,
  input  logic [CMD_TAG_WIDTH-1:0] cmd_tag,
  output logic                     rd_req_valid,
  input  logic                     rd_req_ready,
  output logic [ADDR_WIDTH-1:0]    rd_req_addr,
  output logic [NUM_LANES-1:0]     rd_req_mask,
  output logic [SLOT_BITS-1:0]     rd_req_tag,
  input  logic                     rd_rsp_valid,
  output logic                     rd_rsp_ready,
  input  logic [SLOT_BITS-1:0]     rd_rsp_tag,
  input  logic [DATA_BITS-1:0]     rd_rsp_data,
  output logic                     lmem_wr_valid,
  input  logic                     lmem_wr_ready,
  output logic [ADDR_WIDTH-1:0]    lmem_wr_addr,
  output logic [NUM_LANES-1:0]     lmem_wr_mask,
  output logic [DATA_BITS-1:0]     lmem_wr_data,
  output logic                     done_valid,
  input  logic                     done_ready,
  output logic [CMD_TAG_WIDTH-1:0] done_tag,
  output logic                     busy
`ifdef TMA_PERF_EN
  ,
  output logic [31:0]              perf_beats,
  output logic [31:0]              perf_stall_cycles
`endif
);

  localparam int LANE_W = $clog2(NUM_LANES + 1);
  localparam int PEND_W = SLOT_BITS + 1;

  tma_state_e state, state_next;

  logic [ADDR_WIDTH-1:0]    src_row, dst_row, src_stride_q, dst_stride_q;
  logic [DIM_WIDTH-1:0]     rows_q, cols_q, row_q, col_q;
  logic [CMD_TAG_WIDTH-1:0] tag_q;
  logic [PEND_W-1:0]        pending;

  logic [ADDR_WIDTH-1:0]    slot_addr [MAX_PENDING];
  logic [NUM_LANES-1:0]     slot_mask [MAX_PENDING];

  logic                     cmd_fire, req_fire, rsp_fire, issue_en, empty_desc;
  logic                     slot_avail;
  logic [SLOT_BITS-1:0]     slot_idx;
  logic [MAX_PENDING-1:0]   slot_free;
  logic [DIM_WIDTH-1:0]     remaining, col_next;
  logic [LANE_W-1:0]        beat_words;
  logic [NUM_LANES-1:0]     beat_mask;
  logic [ADDR_WIDTH-1:0]    col_bytes;
  logic                     row_end, last_beat;

  assign cmd_fire   = cmd_valid & cmd_ready;
  assign req_fire   = rd_req_valid & rd_req_ready;
  assign rsp_fire   = rd_rsp_valid & lmem_wr_ready;
  assign empty_desc = (cmd_desc.rows == '0) || (cmd_desc.cols == '0);

  vx_tma_tile_dma_alloc #(
    .SIZE (MAX_PENDING)
  ) u_alloc (
    .clk       (clk),
    .reset     (reset),
    .acq       (req_fire),
    .rel       (rsp_fire),
    .rel_idx   (rd_rsp_tag),
    .avail     (slot_avail),
    .alloc_idx (slot_idx),
    .free_mask (slot_free)
  );

  // Beat geometry for the current walker position
  always_comb begin
    remaining  = cols_q - col_q;
    beat_words = (remaining >= DIM_WIDTH'(NUM_LANES)) ? LANE_W'(NUM_LANES) : LANE_W'(remaining);
    for (int i = 0; i < NUM_LANES; i++) begin
      beat_mask[i] = (LANE_W'(i) < beat_words);
    end
    col_next  = col_q + DIM_WIDTH'(beat_words);
    col_bytes = ADDR_WIDTH'(col_q) * ADDR_WIDTH'(WORD_SIZE);
    row_end   = (col_next == cols_q);
    last_beat = row_end && (row_q == rows_q - DIM_WIDTH'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= TMA_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      TMA_IDLE:  if (cmd_fire) state_next = empty_desc ? TMA_DONE : TMA_ISSUE;
      TMA_ISSUE: if (req_fire && last_beat) state_next = TMA_DRAIN;
      TMA_DRAIN: if ((pending == '0) && !rsp_fire) state_next = TMA_DONE;
      TMA_DONE:  if (done_ready) state_next = TMA_IDLE;
      default:   state_next = TMA_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready    = (state == TMA_IDLE);
    busy         = (state != TMA_IDLE);
    done_valid   = (state == TMA_DONE);
    issue_en     = (state == TMA_ISSUE);
    rd_req_valid = issue_en && slot_avail;
  end

  assign rd_req_addr   = src_row + col_bytes;
  assign rd_req_mask   = beat_mask;
  assign rd_req_tag    = slot_idx;
  assign rd_rsp_ready  = lmem_wr_ready;
  assign lmem_wr_valid = rd_rsp_valid;
  assign lmem_wr_addr  = slot_addr[rd_rsp_tag];
  assign lmem_wr_mask  = slot_mask[rd_rsp_tag];
  assign lmem_wr_data  = rd_rsp_data;
  assign done_tag      = tag_q;

  // Row/column walker; address registers wrap naturally
  always_ff @(posedge clk) begin
    if (cmd_fire) begin
      src_row      <= ADDR_WIDTH'(cmd_desc.src_base);
      dst_row      <= ADDR_WIDTH'(cmd_desc.dst_base);
      src_stride_q <= ADDR_WIDTH'(cmd_desc.src_stride);
      dst_stride_q <= ADDR_WIDTH'(cmd_desc.dst_stride);
      rows_q       <= DIM_WIDTH'(cmd_desc.rows);
      cols_q       <= DIM_WIDTH'(cmd_desc.cols);
      row_q        <= '0;
      col_q        <= '0;
    end else if (req_fire) begin
      if (row_end) begin
        col_q   <= '0;
        row_q   <= row_q + DIM_WIDTH'(1);
        src_row <= src_row + src_stride_q;
        dst_row <= dst_row + dst_stride_q;
      end else begin
        col_q <= col_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q <= '0;
    end else if (cmd_fire) begin
      tag_q <= cmd_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      slot_addr[slot_idx] <= dst_row + col_bytes;
      slot_mask[slot_idx] <= beat_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      case ({req_fire, rsp_fire})
        2'b10:   pending <= pending + PEND_W'(1);
        2'b01:   pending <= pending - PEND_W'(1);
        default: pending <= pending;
      endcase
    end
  end

`ifdef TMA_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_beats        <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (req_fire) perf_beats <= sat_inc(perf_beats);
      if (rd_req_valid && !rd_req_ready) perf_stall_cycles <= sat_inc(perf_stall_cycles);
    end
  end
`endif

  a_rsp_state: assert property (@(posedge clk) disable iff (reset)
    rd_rsp_valid |-> (state == TMA_ISSUE || state == TMA_DRAIN));
  a_rsp_slot: assert property (@(posedge clk) disable iff (reset)
    rd_rsp_valid |-> !slot_free[rd_rsp_tag]);

endmodule

// File: tb/tb_vx_tma_tile_dma.sv
// Bench for vx_tma_tile_dma: descriptor-level model feeding a request/write
// scoreboard, with a randomized out-of-order responder.
module tb_vx_tma_tile_dma;
  import vx_tma_tile_dma_pkg::*;

  localparam int NL = 4;
  localparam int WS = 4;
  localparam int MP = 8;
  localparam int TW = 8;
  localparam int SB = tma_slot_bits(MP);
  localparam int DB = NL * WS * 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          cmd_valid, cmd_ready;
  tma_desc_t     cmd_desc;
  logic [TW-1:0] cmd_tag;
  logic          rd_req_valid;
  logic          rd_req_ready = 1'b0;
  logic [31:0]   rd_req_addr;
  logic [NL-1:0] rd_req_mask;
  logic [SB-1:0] rd_req_tag;
  logic          rd_rsp_valid = 1'b0;
  logic          rd_rsp_ready;
  logic [SB-1:0] rd_rsp_tag = '0;
  logic [DB-1:0] rd_rsp_data = '0;
  logic          lmem_wr_valid;
  logic          lmem_wr_ready = 1'b0;
  logic [31:0]   lmem_wr_addr;
  logic [NL-1:0] lmem_wr_mask;
  logic [DB-1:0] lmem_wr_data;
  logic          done_valid, done_ready;
  logic [TW-1:0] done_tag;
  logic          busy;
`ifdef TMA_PERF_EN
  logic [31:0]   perf_beats, perf_stall_cycles;
`endif

  vx_tma_tile_dma #(
    .NUM_LANES(NL), .WORD_SIZE(WS), .MAX_PENDING(MP), .CMD_TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_desc(cmd_desc), .cmd_tag(cmd_tag),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_req_mask(rd_req_mask), .rd_req_tag(rd_req_tag),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_tag(rd_rsp_tag),
    .rd_rsp_data(rd_rsp_data),
    .lmem_wr_valid(lmem_wr_valid), .lmem_wr_ready(lmem_wr_ready), .lmem_wr_addr(lmem_wr_addr),
    .lmem_wr_mask(lmem_wr_mask), .lmem_wr_data(lmem_wr_data),
    .done_valid(done_valid), .done_ready(done_ready), .done_tag(done_tag), .busy(busy)
`ifdef TMA_PERF_EN
    , .perf_beats(perf_beats), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  typedef struct {
    logic [31:0]   src;
    logic [31:0]   dst;
    logic [NL-1:0] mask;
  } beat_t;

  beat_t         exp_req[$];
  logic [TW-1:0] exp_done[$];
  bit            out_v[MP];
  logic [31:0]   out_dst[MP];
  logic [NL-1:0] out_mask[MP];
  logic [DB-1:0] rsp_data_drv = '0;

  int n_checks = 0, n_fail = 0;
  int req_cnt = 0, wr_cnt = 0, done_cnt = 0, done_base = 0, last_req_tag = -1;
  int rsp_mode = 0, force_tag = 0, req_rate = 100, wr_rate = 100;

  task automatic chk(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic tma_desc_t mk_desc(input logic [31:0] src, input logic [31:0] dst,
                                        input logic [31:0] ss, input logic [31:0] ds,
                                        input int rows, input int cols);
    tma_desc_t d;
    d.src_base = src; d.dst_base = dst; d.src_stride = ss; d.dst_stride = ds;
    d.rows = 16'(rows); d.cols = 16'(cols);
    return d;
  endfunction

  // Tile model: every row split into NUM_LANES-word beats, last beat partial
  task automatic push_model(input tma_desc_t d);
    for (int r = 0; r < int'(d.rows); r++) begin
      int c;
      c = 0;
      while (c < int'(d.cols)) begin
        int n;
        beat_t b;
        n = (int'(d.cols) - c < NL) ? int'(d.cols) - c : NL;
        b.src  = d.src_base + d.src_stride * 32'(r) + 32'(c * WS);
        b.dst  = d.dst_base + d.dst_stride * 32'(r) + 32'(c * WS);
        b.mask = NL'((1 << n) - 1);
        exp_req.push_back(b);
        c += n;
      end
    end
  endtask

  function automatic int outstanding();
    int n = 0;
    for (int i = 0; i < MP; i++) if (out_v[i]) n++;
    return n;
  endfunction

  always @(negedge clk) begin : monitor
    beat_t b;
    if (!reset) begin
      if (rd_req_valid && rd_req_ready) begin
        req_cnt++;
        last_req_tag = int'(rd_req_tag);
        if (exp_req.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL req_unexpected: got addr 0x%0h, expected no request", rd_req_addr);
        end else begin
          b = exp_req.pop_front();
          chk("req_addr", DB'(rd_req_addr), DB'(b.src));
          chk("req_mask", DB'(rd_req_mask), DB'(b.mask));
          chk("req_slot_free", DB'(out_v[rd_req_tag]), DB'(0));
          out_v[rd_req_tag]    = 1'b1;
          out_dst[rd_req_tag]  = b.dst;
          out_mask[rd_req_tag] = b.mask;
        end
      end
      if (rd_rsp_valid && lmem_wr_ready) begin
        wr_cnt++;
        chk("wr_valid", DB'(lmem_wr_valid), DB'(1));
        chk("wr_addr", DB'(lmem_wr_addr), DB'(out_dst[rd_rsp_tag]));
        chk("wr_mask", DB'(lmem_wr_mask), DB'(out_mask[rd_rsp_tag]));
        chk("wr_data", lmem_wr_data, rsp_data_drv);
        out_v[rd_rsp_tag] = 1'b0;
      end
      if (done_valid && done_ready) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL done_unexpected: got tag 0x%0h, expected no completion", done_tag);
        end else begin
          chk("done_tag", DB'(done_tag), DB'(exp_done.pop_front()));
        end
        chk("done_after_writes", DB'(exp_req.size() + outstanding()), DB'(0));
      end
    end
  end

  // Responder: picks an outstanding slot per the active mode
  always @(posedge clk) begin : responder
    int cands[$];
    int pick;
    bit go;
    #1;
    rd_req_ready  = ($urandom_range(99) < req_rate);
    lmem_wr_ready = ($urandom_range(99) < wr_rate);
    cands.delete();
    for (int i = 0; i < MP; i++) if (out_v[i]) cands.push_back(i);
    go = 1'b0;
    pick = 0;
    case (rsp_mode)
      1: if (cands.size() > 0 && $urandom_range(99) < 70) begin
           go = 1'b1; pick = cands[$urandom_range(cands.size() - 1)];
         end
      2: if (cands.size() > 0) begin go = 1'b1; pick = cands[cands.size() - 1]; end
      3: if (out_v[force_tag]) begin go = 1'b1; pick = force_tag; end
      default: go = 1'b0;
    endcase
    rd_rsp_valid = go;
    if (go) begin
      rd_rsp_tag   = SB'(pick);
      rsp_data_drv = {$urandom, $urandom, $urandom, $urandom};
      rd_rsp_data  = rsp_data_drv;
    end
  end

  task automatic issue_cmd(input tma_desc_t d, input logic [TW-1:0] tag);
    bit got = 1'b0;
    push_model(d);
    exp_done.push_back(tag);
    done_base = done_cnt;
    @(posedge clk); #1;
    cmd_desc = d; cmd_tag = tag; cmd_valid = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL cmd_accept: got cmd_ready=0 for 500 cycles, expected 1");
    end
  endtask

  task automatic wait_done(input int bound);
    bit ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk); #1;
      if (done_cnt > done_base) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL done_timeout: got no completion in %0d cycles, expected one", bound);
    end
    chk("drained", DB'(exp_req.size()), DB'(0));
    @(posedge clk); #1;
  endtask

  task automatic wait_reqs(input int target, input int bound, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk); #1;
      if (req_cnt >= target) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d requests, expected %0d", name, req_cnt, target);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int base, wbase;
    reset = 1'b1; cmd_valid = 1'b0; cmd_desc = '0; cmd_tag = '0; done_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", DB'(cmd_ready), DB'(1));
    chk("rst_req_valid", DB'(rd_req_valid), DB'(0));
    chk("rst_wr_valid", DB'(lmem_wr_valid), DB'(0));
    chk("rst_done_valid", DB'(done_valid), DB'(0));
    chk("rst_busy", DB'(busy), DB'(0));
    chk("rst_done_tag", DB'(done_tag), DB'(0));

    // T1 single full beat
    rsp_mode = 1; base = req_cnt; wbase = wr_cnt;
    issue_cmd(mk_desc(32'h1000, 32'h100, 32'h0, 32'h0, 1, 4), 8'h11);
    wait_done(200);
    chk("t1_reqs", DB'(req_cnt - base), DB'(1));
    chk("t1_writes", DB'(wr_cnt - wbase), DB'(1));

    // T2 two rows with partial tail beats
    base = req_cnt; wbase = wr_cnt;
    issue_cmd(mk_desc(32'h1000, 32'h100, 32'h40, 32'h20, 2, 6), 8'h22);
    wait_done(200);
    chk("t2_reqs", DB'(req_cnt - base), DB'(4));
    chk("t2_writes", DB'(wr_cnt - wbase), DB'(4));

    // T3 responses withheld: stall at MAX_PENDING, then reuse of released slot 3
    rsp_mode = 0; base = req_cnt;
    issue_cmd(mk_desc(32'h2000, 32'h800, 32'h0, 32'h0, 1, 40), 8'h33);
    repeat (20) @(negedge clk);
    chk("t3_req_count", DB'(req_cnt - base), DB'(MP));
    chk("t3_req_valid_low", DB'(rd_req_valid), DB'(0));
    force_tag = 3; rsp_mode = 3;
    wait_reqs(base + MP + 1, 50, "t3_next_req");
    chk("t3_slot_reuse", DB'(last_req_tag), DB'(3));
    rsp_mode = 1;
    wait_done(500);

    // T4 reverse tag order with lmem_wr_ready toggling
    rsp_mode = 0; wr_rate = 50; base = req_cnt; wbase = wr_cnt;
    issue_cmd(mk_desc(32'h3000, 32'h900, 32'h100, 32'h80, 2, 14), 8'h44);
    wait_reqs(base + 8, 100, "t4_issue_all");
    rsp_mode = 2;
    wait_done(500);
    chk("t4_writes", DB'(wr_cnt - wbase), DB'(8));
    wr_rate = 100; rsp_mode = 1;

    // T5 empty tile, completion held off
    done_ready = 1'b0; base = req_cnt;
    issue_cmd(mk_desc(32'h4000, 32'hA00, 32'h0, 32'h0, 3, 0), 8'h55);
    @(negedge clk);
    chk("t5_done_next_cycle", DB'(done_valid), DB'(1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_done_held", DB'(done_valid), DB'(1));
      chk("t5_cmd_ready_low", DB'(cmd_ready), DB'(0));
    end
    @(posedge clk); #1 done_ready = 1'b1;
    wait_done(20);
    @(negedge clk);
    chk("t5_cmd_ready_after", DB'(cmd_ready), DB'(1));
    chk("t5_no_reqs", DB'(req_cnt - base), DB'(0));

    // T6 reset with three reads in flight
    rsp_mode = 0; req_rate = 100; base = req_cnt;
    issue_cmd(mk_desc(32'h5000, 32'hB00, 32'h0, 32'h0, 1, 40), 8'h66);
    wait_reqs(base + 3, 50, "t6_three_reqs");
    req_rate = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    exp_req.delete(); exp_done.delete();
    for (int i = 0; i < MP; i++) out_v[i] = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_busy", DB'(busy), DB'(0));
    chk("t6_cmd_ready", DB'(cmd_ready), DB'(1));
    chk("t6_req_valid", DB'(rd_req_valid), DB'(0));
    chk("t6_done_valid", DB'(done_valid), DB'(0));
    req_rate = 100; rsp_mode = 1;
    issue_cmd(mk_desc(32'h6000, 32'hC00, 32'h20, 32'h40, 3, 5), 8'h77);
    wait_done(500);

    // Randomized descriptors, including address wrap-around
    for (int t = 0; t < 10; t++) begin
      logic [31:0] src, dst;
      src = (t == 3) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      dst = (t == 5) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      rsp_mode = int'($urandom_range(1, 2));
      req_rate = int'($urandom_range(30, 100));
      wr_rate  = int'($urandom_range(30, 100));
      issue_cmd(mk_desc(src, dst, $urandom & 32'h0000_FFFC, $urandom & 32'h0000_FFFC,
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 13))),
                8'($urandom));
      wait_done(2000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
